// File: rtl/note_player.sv
// note_player: programmable square-wave note generator for the buzzer.
// It accepts one {note, octave, duration} command at a time over a
// valid/ready handshake. It plays the tone for the requested number of
// milliseconds and then holds a silent articulation gap.
//
// Ports:
//   clock_in   system clock, rising edge
//   reset      synchronous, active-high
//   in_valid   command valid
//   in_ready   command can be accepted (IDLE only)
//   in_note    0..11 = C..B, 12..15 = rest
//   in_oct     octave shift 0..3 (divisor >> in_oct)
//   in_dur     note length in ms
//   tone_out   square wave to buzzer
//   busy       high while playing or in the gap
//   done       one-cycle pulse when a command completes
//
// State table:
//   S_IDLE | waiting for a command, in_ready high
//   S_PLAY | tone (or rest) running for dur ms
//   S_GAP  | silent articulation gap of GAP_MS ms
module note_player #(
  parameter int MS_DIV = 50000,
  parameter int GAP_MS = 10,
  parameter int DUR_W  = 8,
  parameter int CNT_W  = 28
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_note,
  input  logic [1:0]       in_oct,
  input  logic [DUR_W-1:0] in_dur,
  output logic             tone_out,
  output logic             busy,
  output logic             done
);

  localparam int               PRE_W    = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_DIV - 1);
  localparam logic             HAS_GAP  = (GAP_MS > 0);
  localparam logic [DUR_W-1:0] GAP_LAST = (GAP_MS > 0) ? DUR_W'(GAP_MS - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   tone_cnt, tone_cnt_nxt;
  logic [CNT_W-1:0]   div_q, div_nxt;
  logic [CNT_W-1:0]   half_q, half_nxt;
  logic [PRE_W-1:0]   pre_cnt, pre_nxt;
  logic [DUR_W-1:0]   ms_cnt, ms_nxt;
  logic [DUR_W-1:0]   dur_q, dur_nxt;
  logic               rest_q, rest_nxt;
  logic               tone_nxt, done_nxt;
  logic               tick;
  logic [PRE_W-1:0]   pre_step;
  logic [CNT_W-1:0]   div_new;

  // Octave-4 half-period-pair divisors at 50 MHz
  function automatic logic [17:0] base_div(input logic [3:0] note);
    case (note)
      4'd0:    base_div = 18'd191113;
      4'd1:    base_div = 18'd180386;
      4'd2:    base_div = 18'd170262;
      4'd3:    base_div = 18'd160706;
      4'd4:    base_div = 18'd151686;
      4'd5:    base_div = 18'd143172;
      4'd6:    base_div = 18'd135137;
      4'd7:    base_div = 18'd127553;
      4'd8:    base_div = 18'd120395;
      4'd9:    base_div = 18'd113636;
      4'd10:   base_div = 18'd107259;
      4'd11:   base_div = 18'd101238;
      // rests never drive the tone; any nonzero divisor keeps the counter tidy
      default: base_div = 18'd191113;
    endcase
  endfunction

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign tick     = (pre_cnt == PRE_LAST);
  assign pre_step = tick ? '0 : pre_cnt + 1'b1;
  assign div_new  = CNT_W'(base_div(in_note)) >> in_oct;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state    <= S_IDLE;
      tone_cnt <= '0;
      div_q    <= '0;
      half_q   <= '0;
      pre_cnt  <= '0;
      ms_cnt   <= '0;
      dur_q    <= '0;
      rest_q   <= 1'b0;
      tone_out <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      tone_cnt <= tone_cnt_nxt;
      div_q    <= div_nxt;
      half_q   <= half_nxt;
      pre_cnt  <= pre_nxt;
      ms_cnt   <= ms_nxt;
      dur_q    <= dur_nxt;
      rest_q   <= rest_nxt;
      tone_out <= tone_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    tone_cnt_nxt = tone_cnt;
    div_nxt      = div_q;
    half_nxt     = half_q;
    pre_nxt      = pre_cnt;
    ms_nxt       = ms_cnt;
    dur_nxt      = dur_q;
    rest_nxt     = rest_q;
    tone_nxt     = 1'b0;
    done_nxt     = 1'b0;

    case (state)
      S_IDLE: begin
        if (in_valid) begin
          div_nxt      = div_new;
          half_nxt     = div_new >> 1;
          rest_nxt     = (in_note >= 4'd12);
          dur_nxt      = in_dur;
          tone_cnt_nxt = '0;
          pre_nxt      = '0;
          ms_nxt       = '0;
          if (in_dur != '0)
            state_nxt = S_PLAY;
          else if (HAS_GAP)
            state_nxt = S_GAP;
          else
            done_nxt = 1'b1;
        end
      end

      S_PLAY: begin
        tone_cnt_nxt = (tone_cnt >= div_q - 1'b1) ? '0 : tone_cnt + 1'b1;
        tone_nxt     = !rest_q && (tone_cnt < half_q);
        pre_nxt      = pre_step;
        if (tick)
          ms_nxt = ms_cnt + 1'b1;
        // the last tick of the last ms ends the note, cutting any partial period
        if (tick && (ms_cnt == dur_q - 1'b1)) begin
          tone_nxt = 1'b0;
          pre_nxt  = '0;
          ms_nxt   = '0;
          if (HAS_GAP) begin
            state_nxt = S_GAP;
          end else begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end

      S_GAP: begin
        pre_nxt = pre_step;
        if (tick)
          ms_nxt = ms_cnt + 1'b1;
        if (tick && (ms_cnt == GAP_LAST)) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
          pre_nxt   = '0;
          ms_nxt    = '0;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
